imem_loader: RTL

Boot-time writer for the 16-bit instruction memory. It receives a framed byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words and drives the instruction memory write port. It holds the pipeline in reset while a frame is in flight and reports completion or error. It sits between the host/UART byte receiver and the instruction memory, so the core can be reprogrammed without touching the ROM initialisation.

---
 rtl/imem_loader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time loader for the 16-bit instruction memory. Receives a framed
//   byte stream (SYNC, ADDR_H, ADDR_L, CNT_H, CNT_L, CNT x {hi, lo}, CSUM),
//   assembles big-endian words and drives the instruction memory write port.
//   The core is held in reset (cpu_hold) while a frame is in flight.
//
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   asynchronous, active-low reset
//   rx_data   in   [7:0] incoming byte
//   rx_valid  in   rx_data valid
//   rx_ready  out  loader can accept a byte (decoded from state)
//   wr_en     out  instruction memory write strobe, one cycle per word
//   wr_addr   out  [15:0] word address (start + index, wraps at 16 bits)
//   wr_data   out  [15:0] instruction word
//   cpu_hold  out  high while a frame is being loaded
//   done      out  one-cycle pulse at the end of every frame
//   load_ok   out  sticky: last frame completed with a matching checksum
//   load_err  out  sticky: last frame failed (checksum mismatch or timeout)
module imem_loader #(
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        load_ok,
  output logic        load_err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_H,
    S_ADDR_L,
    S_CNT_H,
    S_CNT_L,
    S_DATA_H,
    S_DATA_L,
    S_WRITE,
    S_CSUM,
    S_FINISH
  } state_t;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The abort happens on the edge where the idle count would reach
  // TIMEOUT_CYCLES, so the counter itself never exceeds TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_reg;
  logic [7:0]    sum_reg;
  logic [15:0]   start_reg;
  logic [15:0]   cnt_reg;
  logic [16:0]   index_reg;   // 17 bits so CNT = 0xFFFF terminates exactly
  logic [7:0]    hi_reg;
  logic [TW-1:0] idle_reg;

  logic          accept;
  logic          timed;
  logic [16:0]   index_inc;

  assign rx_ready  = (state_reg != S_WRITE) && (state_reg != S_FINISH);
  assign accept    = rx_valid && rx_ready;
  // Timeout supervision applies to every byte-accepting state except IDLE.
  assign timed     = rx_ready && (state_reg != S_IDLE);
  assign index_inc = index_reg + 17'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      sum_reg   <= '0;
      start_reg <= '0;
      cnt_reg   <= '0;
      index_reg <= '0;
      hi_reg    <= '0;
      idle_reg  <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      load_ok   <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;

      if (timed && !accept) begin
        if (idle_reg == IDLE_LAST) begin
          load_err  <= 1'b1;
          done      <= 1'b1;
          cpu_hold  <= 1'b0;
          state_reg <= S_FINISH;
        end else begin
          idle_reg <= idle_reg + 1'b1;
        end
      end else begin
        idle_reg <= '0;
        // In the byte states below, reaching this branch implies accept.
        case (state_reg)
          S_IDLE: begin
            if (accept && rx_data == SYNC_BYTE) begin
              load_ok   <= 1'b0;
              load_err  <= 1'b0;
              sum_reg   <= '0;
              index_reg <= '0;
              cpu_hold  <= 1'b1;
              state_reg <= S_ADDR_H;
            end
          end
          S_ADDR_H: begin
            start_reg[15:8] <= rx_data;
            sum_reg         <= sum_reg + rx_data;
            state_reg       <= S_ADDR_L;
          end
          S_ADDR_L: begin
            start_reg[7:0] <= rx_data;
            sum_reg        <= sum_reg + rx_data;
            state_reg      <= S_CNT_H;
          end
          S_CNT_H: begin
            cnt_reg[15:8] <= rx_data;
            sum_reg       <= sum_reg + rx_data;
            state_reg     <= S_CNT_L;
          end
          S_CNT_L: begin
            cnt_reg[7:0] <= rx_data;
            sum_reg      <= sum_reg + rx_data;
            state_reg    <= ({cnt_reg[15:8], rx_data} != 16'd0) ? S_DATA_H : S_CSUM;
          end
          S_DATA_H: begin
            hi_reg    <= rx_data;
            sum_reg   <= sum_reg + rx_data;
            state_reg <= S_DATA_L;
          end
          S_DATA_L: begin
            sum_reg   <= sum_reg + rx_data;
            wr_en     <= 1'b1;
            wr_addr   <= start_reg + index_reg[15:0];
            wr_data   <= {hi_reg, rx_data};
            state_reg <= S_WRITE;
          end
          S_WRITE: begin
            index_reg <= index_inc;
            state_reg <= (index_inc < {1'b0, cnt_reg}) ? S_DATA_H : S_CSUM;
          end
          S_CSUM: begin
            if (rx_data == sum_reg) load_ok  <= 1'b1;
            else                    load_err <= 1'b1;
            done      <= 1'b1;
            cpu_hold  <= 1'b0;
            state_reg <= S_FINISH;
          end
          S_FINISH: state_reg <= S_IDLE;
          default:  state_reg <= S_IDLE;
        endcase
      end
    end
  end

endmodule
